// File: rtl/maze_mem_arbiter_pkg.sv
// maze_mem_arbiter_pkg: shared maze widths, client ids and tag type
package maze_mem_arbiter_pkg;
  localparam int MAZE_WIDTH_DEF = 6;
  localparam int CID_W = 1;
  typedef logic [CID_W-1:0] cid_t;
  localparam cid_t CLIENT0 = 1'b0;
  localparam cid_t CLIENT1 = 1'b1;
  typedef struct packed {
    logic valid;
    cid_t id;
  } tag_t;
endpackage

// File: rtl/maze_rr_pick.sv
// maze_rr_pick: lock-aware round-robin choice between two eligible clients
module maze_rr_pick
  import maze_mem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  cid_t       last_grant,
  input  tag_t       lock_owner,
  output logic [1:0] grant
);
  logic hold;
  assign hold = lock_owner.valid && eligible[lock_owner.id];
  assign grant = hold ? 2'b01 << lock_owner.id
               : &eligible ? (last_grant == CLIENT0 ? 2'b10 : 2'b01)
               : eligible;
endmodule

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: two-client arbiter for the single-bit maze cell memory
module maze_mem_arbiter
  import maze_mem_arbiter_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [maze_width-1:0] row0,
  input  logic [maze_width-1:0] col0,
  input  logic [maze_width-1:0] row1,
  input  logic [maze_width-1:0] col1,
  input  logic                  oe0,
  input  logic                  we0,
  input  logic                  oe1,
  input  logic                  we1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rdata,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  input  logic                  maze_in
);
  logic [1:0] elig, pick, gnt;
  tag_t lock_q, lock_d, rd1_q, rd1_d, rd2_q;
  cid_t last_q, last_d, gid;
  logic [maze_width-1:0] row_q, row_d, col_q, col_d;
  logic oe_q, oe_d, we_q, we_d, g_oe, g_we, g_lock, any;
  assign elig = {req1 & (oe1 | we1), req0 & (oe0 | we0)};
  maze_rr_pick u_pick (
    .eligible  (elig),
    .last_grant(last_q),
    .lock_owner(lock_q),
    .grant     (pick)
  );
  assign gnt  = rst ? 2'b00 : pick;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign any  = |gnt;
  always_comb begin
    gid    = gnt[1] ? CLIENT1 : CLIENT0;
    g_oe   = gnt[1] ? oe1 : oe0;
    g_we   = gnt[1] ? we1 : we0;
    g_lock = gnt[1] ? lock1 : lock0;
    last_d = any ? gid : last_q;
    lock_d = '{valid: any && g_lock, id: gid};
    // write wins when both selectors are set, so such a grant never returns data
    oe_d   = any && g_oe && !g_we;
    we_d   = any && g_we;
    rd1_d  = '{valid: oe_d, id: gid};
    row_d  = any ? (gnt[1] ? row1 : row0) : row_q;
    col_d  = any ? (gnt[1] ? col1 : col0) : col_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= CLIENT1;
      lock_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      oe_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd1_q;
      row_q  <= row_d;
      col_q  <= col_d;
      oe_q   <= oe_d;
      we_q   <= we_d;
    end
  end
  assign row     = row_q;
  assign col     = col_q;
  assign maze_oe = oe_q;
  assign maze_we = we_q;
  assign rvalid0 = rd2_q.valid && rd2_q.id == CLIENT0;
  assign rvalid1 = rd2_q.valid && rd2_q.id == CLIENT1;
  assign rdata   = maze_in;
endmodule
